// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined barrel shifter (SLL/SRL/SRA/ROL), one shamt bit per stage
// Stage k applies a 2^k shift; bubble-collapsing valid/ready flow control.
module pipelined_barrel_shifter #(
   parameter  int WIDTH = 16,
   localparam int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SW-1:0]    in_shamt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero
);

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;

   logic [SW-1:0]    v_q;
   logic [SW-1:0]    ld;
   logic [SW-1:0]    src_v;
   logic [WIDTH-1:0] d_q   [SW];
   logic [WIDTH-1:0] src_d [SW];
   logic [WIDTH-1:0] sh_d  [SW];
   logic [SW-1:0]    s_q   [SW];
   logic [SW-1:0]    src_s [SW];
   logic [1:0]       m_q   [SW];
   logic [1:0]       src_m [SW];
   logic             zero_q;

   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       m,
                                                   input logic             en,
                                                   input int               k);
      logic [WIDTH-1:0] r;
      int               n;
      n = 1 << k;
      r = d;
      if (en) begin
         case (m)
            MODE_SLL: r = d << n;
            MODE_SRL: r = d >> n;
            MODE_SRA: r = WIDTH'($signed(d) >>> n);
            default:  r = (d << n) | (d >> (WIDTH - n));
         endcase
      end
      return r;
   endfunction

   // A stage may load unless it and every stage downstream of it is full while out_ready is low.
   always_comb begin
      ld       = '0;
      src_v[0] = in_valid;
      src_d[0] = in_data;
      src_s[0] = in_shamt;
      src_m[0] = in_mode;
      for (int k = 1; k < SW; k++) begin
         src_v[k] = v_q[k-1];
         src_d[k] = d_q[k-1];
         src_s[k] = s_q[k-1];
         src_m[k] = m_q[k-1];
      end
      for (int k = 0; k < SW; k++) begin
         ld[k]   = out_ready || !(&(v_q | SW'((1 << k) - 1)));
         sh_d[k] = shift_step(src_d[k], src_m[k], src_s[k][k], k);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= '0;
         zero_q <= 1'b0;
         for (int k = 0; k < SW; k++) begin
            d_q[k] <= '0;
            s_q[k] <= '0;
            m_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < SW; k++) begin
            if (ld[k]) begin
               v_q[k] <= src_v[k];
               if (src_v[k]) begin
                  d_q[k] <= sh_d[k];
                  s_q[k] <= src_s[k];
                  m_q[k] <= src_m[k];
               end
            end
         end
         if (ld[SW-1] && src_v[SW-1]) begin
            zero_q <= (sh_d[SW-1] == '0);
         end
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v_q[SW-1];
   assign out_data  = d_q[SW-1];
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - scoreboard testbench for pipelined_barrel_shifter
// Driver pushes expected results on each accept; a negedge monitor pops and compares.
module tb_pipelined_barrel_shifter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_shamt;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_zero;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic        chk_lat  = 1'b1;
   logic [15:0] exp_q [$];
   int          cyc_q [$];

   pipelined_barrel_shifter #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: whole-operation arithmetic on the full shift amount.
   function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m);
      int          sx;
      logic [31:0] t;
      case (m)
         2'd0: return d << s;
         2'd1: return d >> s;
         2'd2: begin
            sx = int'($signed(d));
            return 16'(sx >>> s);
         end
         default: begin
            t = {d, d} << s;
            return t[31:16];
         end
      endcase
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [15:0] e;
      int          c;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               c = cyc_q.pop_front();
               chk("out_data", out_data, e);
               chk("out_zero", out_zero, e == 16'h0);
               if (chk_lat) chk("latency", cyc - c, 4);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_data, in_shamt, in_mode));
            cyc_q.push_back(cyc);
         end
      end
   end

   task automatic send(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m);
      int w = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_mode  = m;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_shamt = 4'($urandom);
      in_mode  = 2'($urandom);
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held_d;
      logic        held_z;
      int          acc;
      int          ops;
      int          guard;
      logic        took;

      rst_n     = 1'b0;
      out_ready = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_zero", out_zero, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Mode sweep
      send(16'hFFFF, 4'd1, 2'd0);
      send(16'h8001, 4'd4, 2'd2);
      send(16'h8001, 4'd15, 2'd1);
      send(16'h8001, 4'd1, 2'd3);
      idle();
      drain();
      // Shift-amount walk, back to back
      send(16'hFFFF, 4'd0, 2'd0);
      send(16'hFFFF, 4'd1, 2'd0);
      send(16'hFFFF, 4'd2, 2'd0);
      send(16'hFFFF, 4'd4, 2'd0);
      send(16'hFFFF, 4'd8, 2'd0);
      idle();
      drain();
      // Zero flag and shift 0 in other modes
      send(16'h0001, 4'd1, 2'd1);
      send(16'h0001, 4'd15, 2'd3);
      send(16'hA5C3, 4'd0, 2'd2);
      send(16'hA5C3, 4'd0, 2'd3);
      idle();
      drain();

      // Backpressure
      chk_lat   = 1'b0;
      out_ready = 1'b0;
      acc       = 0;
      for (int i = 0; i < 12 && acc < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         in_shamt = 4'($urandom);
         in_mode  = 2'($urandom);
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk);
         #1;
      end
      chk("bp_accepts", acc, 4);
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      held_d = out_data;
      held_z = out_zero;
      repeat (3) @(negedge clk);
      chk("bp_data_stable", out_data, held_d);
      chk("bp_zero_stable", out_zero, held_z);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(16'($urandom), 4'($urandom), 2'($urandom));
      send(16'($urandom), 4'($urandom), 2'($urandom));
      idle();
      drain();

      // Reset with operations in flight
      out_ready = 1'b0;
      send(16'h1234, 4'd3, 2'd0);
      send(16'h8765, 4'd5, 2'd2);
      send(16'h0F0F, 4'd7, 2'd3);
      idle();
      @(posedge clk);
      #2;
      chk("pre_rst_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_out_data", out_data, 0);
      chk("async_rst_out_zero", out_zero, 0);
      exp_q.delete();
      cyc_q.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      repeat (8) @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
      @(posedge clk);
      #1;
      chk_lat = 1'b1;
      send(16'h00F0, 4'd4, 2'd1);
      idle();
      drain();

      // Randomised traffic
      chk_lat = 1'b0;
      ops     = 0;
      guard   = 0;
      while (ops < 1000 && guard < 20000) begin
         @(negedge clk);
         took = in_valid && in_ready;
         if (took) ops++;
         @(posedge clk);
         #1;
         guard++;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid || took) begin
            if (ops < 1000 && $urandom_range(0, 3) != 0) begin
               in_valid = 1'b1;
               in_data  = 16'($urandom);
               in_shamt = 4'($urandom);
               in_mode  = 2'($urandom);
            end else begin
               idle();
            end
         end
      end
      chk("random_ops_issued", ops, 1000);
      idle();
      out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, pipelined successor to the 16-bit combinational barrel shifter. It accepts one operand per cycle over a valid/ready handshake and supports four shift modes: logical left, logical right, arithmetic right and rotate left. It resolves one shift-amount bit per pipeline stage and registers every stage. It sits in the datapath between the operand-issue logic and the result-writeback stage, and supports full throughput and downstream backpressure.

## Interface
- `WIDTH`, 16, data width; power of two, >= 4.
- `SW`, `$clog2(WIDTH)`, shift-amount width and pipeline depth; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand presented.
- `in_ready`  out  1  block can accept this cycle.
- `in_data`  in  WIDTH  operand.
- `in_shamt`  in  SW  shift amount, 0..WIDTH-1.
- `in_mode`  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  WIDTH  shifted result.
- `out_zero`  out  1  high when `out_data` == 0; registered with the data.

## Operation
- Transfers:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- Pipeline structure:
  - SW stages, S0..S(SW-1).
  - Each stage holds valid, data, the remaining shamt bits and mode.
  - Stage k applies a shift of 2^k when shamt bit k is set, otherwise passes through.
  - S(SW-1) drives `out_data`, `out_valid` and `out_zero`.
- Mode semantics, per stage shift of n = 2^k:
  - SLL: data << n, zero fill.
  - SRL: data >> n, zero fill.
  - SRA: data >> n, fill with original MSB. Each stage fills with its own input MSB, which equals the operand MSB.
  - ROL: rotate left, bits leaving the MSB re-enter at the LSB.
- The cumulative result equals the single-step operation by `in_shamt`. Shift 0 returns `in_data` unchanged in all modes.
- Bubble-collapsing flow control:
  - Stage k may load when it is empty, or when its content moves to stage k+1 this cycle.
  - The last stage may load when it is empty or `out_ready` is high.
  - `in_ready` equals stage 0 may-load, a combinational chain from `out_ready`.
- `out_zero` is computed from the S(SW-1) next-state data and registered with it.
- While `in_valid` is low, `in_data`, `in_shamt` and `in_mode` are ignored, and no stage captures garbage as valid.
- Reset, asserted at any time including mid-operation:
  - All stage valids clear immediately, so in-flight operations are discarded.
  - `out_valid`=0, `out_data`=0, `out_zero`=0.
  - `in_ready`=1 once reset is released.

## Timing
- Latency: an operand accepted at edge T appears with `out_valid`=1 after edge T+SW-1, i.e. SW cycles of occupancy with no stall. WIDTH=16 gives 4 cycles.
- Throughput: one operation per cycle while `out_ready`=1.
- Backpressure:
  - While `out_valid && !out_ready`, `out_data` and `out_zero` hold stable.
  - Upstream stages keep filling bubbles until full.
  - `in_ready` drops only when all SW stages are valid and `out_ready`=0.
- Full pipeline with simultaneous accept and drain (`out_ready`=1, `in_valid`=1): both transfers occur in the same cycle and no bubble is inserted.
- Empty pipeline: `in_ready`=1 regardless of `out_ready`.
- Ordering is strictly preserved; the pipeline neither drops nor duplicates results.
- The ready path is combinational `out_ready` -> `in_ready`; there is no combinational path from `in_valid` to `out_valid`.

## Test plan
All scenarios use WIDTH=16.
- Mode sweep with `out_ready`=1:
  - 0xFFFF SLL 1 -> 0xFFFE.
  - 0x8001 SRA 4 -> 0xF800.
  - 0x8001 SRL 15 -> 0x0001.
  - 0x8001 ROL 1 -> 0x0003.
  - Each result appears 4 cycles after acceptance, `out_zero`=0.
- Single-bit shamt walk 0, 1, 2, 4, 8 on 0xFFFF SLL -> 0xFFFF, 0xFFFE, 0xFFFC, 0xFFF0, 0xFF00. Back-to-back issue produces back-to-back results.
- Zero flag: 0x0001 SRL 1 -> `out_data`=0x0000 with `out_zero`=1. The next op, 0x0001 ROL 15 -> 0x8000 with `out_zero`=0.
- Backpressure:
  - Hold `out_ready`=0 while streaming 6 operands. `in_ready` falls after the 4th accept.
  - `out_data` stays stable.
  - Release `out_ready`: all accepted results emerge in order, with no loss or duplication.
- Reset mid-flight: assert `rst_n`=0 with 3 ops in the pipeline.
  - Outputs go 0 asynchronously, before the next clock edge.
  - After release, `in_ready`=1 and no stale result appears.
- Randomised 1000 ops, random `in_valid`/`out_ready`, compared against a reference model of all four modes.
